// File: rtl/simon_data_out.sv
`default_nettype none
// ============================================================================
//  Module      : simon_data_out
//  Description : Output packetiser for the SIMON datapath. Accepts 2N-bit
//                result blocks from the cipher core (edge-qualified valid/ack),
//                packs two blocks per packet, prepends info and count bytes
//                and offers the packet to the host under a ready/ack handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module simon_data_out #(
    parameter int         N        = 16,
    parameter logic [7:0] INFO_HDR = 8'hC0
) (
    input  logic                     clk,
    input  logic                     nR,
    input  logic                     doneBlock,
    input  logic [1:0][N-1:0]        blockOUT,
    input  logic                     lastBlock,
    output logic                     takeBlock,
    output logic [(1+N/2):0][7:0]    out,
    output logic                     pktReady,
    input  logic                     pktAck,
    output logic                     busy
);

    // Payload is N/2 bytes; one block fills half of it (N/4 bytes).
    localparam int c_PAY  = N / 2;
    localparam int c_HALF = N / 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HALF   = 2'd1,
        SEND   = 2'd2,
        ACKLOW = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_nextState;

    logic [(1+N/2):0][7:0]    r_out;
    logic [7:0]               r_seqCount;
    logic                     r_pktReady;
    logic                     r_takeBlock;
    logic                     r_armed;      // doneBlock has been low since the last take

    logic                     w_accept;
    logic                     w_capHi;
    logic                     w_capLo;
    logic                     w_zeroLo;
    logic                     w_enterSend;
    logic                     w_ackTake;
    logic [7:0]               w_info;
    logic [c_HALF-1:0][7:0]   w_blockBytes;

    assign w_blockBytes = blockOUT;

    // Info byte: bit0 marks a single (odd) block packet, bit1 marks the
    // message's final block. Odd packets only arise when sending from IDLE.
    assign w_info = INFO_HDR | {6'd0, lastBlock, (r_state == IDLE)};

    // State register.
    always_ff @(posedge clk) begin
        if (nR) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode and one-cycle datapath strobes.
    always_comb begin
        w_nextState = r_state;
        w_capHi     = 1'b0;
        w_capLo     = 1'b0;
        w_zeroLo    = 1'b0;
        w_enterSend = 1'b0;
        w_ackTake   = 1'b0;
        w_accept    = doneBlock && r_armed && ((r_state == IDLE) || (r_state == HALF));
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_capHi = 1'b1;
                    if (lastBlock) begin
                        w_zeroLo    = 1'b1;
                        w_enterSend = 1'b1;
                        w_nextState = SEND;
                    end else begin
                        w_nextState = HALF;
                    end
                end
            end
            HALF: begin
                if (w_accept) begin
                    w_capLo     = 1'b1;
                    w_enterSend = 1'b1;
                    w_nextState = SEND;
                end
            end
            SEND: begin
                if (pktAck) begin
                    w_ackTake   = 1'b1;
                    w_nextState = ACKLOW;
                end
            end
            ACKLOW: begin
                if (!pktAck) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Core-side handshake: registered take pulse and edge-qualification flag.
    always_ff @(posedge clk) begin
        if (nR) begin
            r_takeBlock <= 1'b0;
            r_armed     <= 1'b1;
        end else begin
            r_takeBlock <= w_accept;
            if (w_accept) begin
                r_armed <= 1'b0;
            end else if (!doneBlock) begin
                r_armed <= 1'b1;
            end
        end
    end

    // Packet buffer, host ready flag and sequence counter.
    always_ff @(posedge clk) begin
        if (nR) begin
            r_out      <= '0;
            r_seqCount <= 8'd0;
            r_pktReady <= 1'b0;
        end else begin
            if (w_capHi) begin
                r_out[c_PAY-1 -: c_HALF] <= w_blockBytes;
            end
            if (w_capLo) begin
                r_out[c_HALF-1:0] <= w_blockBytes;
            end
            if (w_zeroLo) begin
                r_out[c_HALF-1:0] <= '0;
            end
            if (w_enterSend) begin
                r_out[c_PAY+1] <= w_info;
                r_out[c_PAY]   <= r_seqCount;
                r_pktReady     <= 1'b1;
            end
            if (w_ackTake) begin
                r_pktReady <= 1'b0;
                r_seqCount <= r_seqCount + 8'd1;
            end
        end
    end

    assign takeBlock = r_takeBlock;
    assign out       = r_out;
    assign pktReady  = r_pktReady;
    assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_simon_data_out.sv
`default_nettype none
// ============================================================================
//  Module      : tb_simon_data_out
//  Description : Scoreboard bench for simon_data_out (N=16). Stimulus pushes
//                expected packets; a negedge monitor pops and compares each
//                time pktReady rises.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_simon_data_out;

    localparam int N = 16;

    logic                  clk;
    logic                  nR;
    logic                  doneBlock;
    logic [1:0][N-1:0]     blockOUT;
    logic                  lastBlock;
    logic                  takeBlock;
    logic [(1+N/2):0][7:0] out;
    logic                  pktReady;
    logic                  pktAck;
    logic                  busy;

    int            checks;
    int            errors;
    int            takeCount;
    logic          prevRdy;
    logic [79:0]   expQ[$];
    logic [79:0]   expPkt;

    simon_data_out #(.N(N), .INFO_HDR(8'hC0)) dut (
        .clk       (clk),
        .nR        (nR),
        .doneBlock (doneBlock),
        .blockOUT  (blockOUT),
        .lastBlock (lastBlock),
        .takeBlock (takeBlock),
        .out       (out),
        .pktReady  (pktReady),
        .pktAck    (pktAck),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: counts take pulses and checks each newly presented packet.
    always @(negedge clk) begin
        if (takeBlock) takeCount = takeCount + 1;
        if (pktReady && !prevRdy) begin
            checks = checks + 1;
            if (expQ.size() == 0) begin
                errors = errors + 1;
                $display("FAIL pkt_unexpected got=%h", out);
            end else begin
                expPkt = expQ.pop_front();
                if (out !== expPkt) begin
                    errors = errors + 1;
                    $display("FAIL pkt got=%h exp=%h", out, expPkt);
                end
            end
        end
        prevRdy = pktReady;
    end

    task automatic chk(input string name, input logic [79:0] got, input logic [79:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Present one block and wait (bounded) for the take pulse; then drop
    // doneBlock for one edge so the next block is a fresh one.
    task automatic sendBlock(input logic [31:0] blk, input logic last, output logic rdyAtTake);
        int n;
        n         = 0;
        blockOUT  = blk;
        lastBlock = last;
        doneBlock = 1'b1;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!takeBlock && n < 20);
        chk("take_seen", {79'd0, takeBlock}, 80'd1);
        rdyAtTake = pktReady;
        doneBlock = 1'b0;
        lastBlock = 1'b0;
        @(posedge clk); #1;
    endtask

    // Wait (bounded) for a packet, ack it for one cycle, return to IDLE.
    task automatic ackPkt();
        int n;
        n = 0;
        while (!pktReady && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ack_ready", {79'd0, pktReady}, 80'd1);
        pktAck = 1'b1;
        @(posedge clk); #1;
        chk("ack_drop", {79'd0, pktReady}, 80'd0);
        pktAck = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic        r;
        logic [7:0]  cnt;
        logic [31:0] a;
        logic [31:0] b;
        int          n;
        checks    = 0;
        errors    = 0;
        takeCount = 0;
        prevRdy   = 1'b0;
        nR        = 1'b1;
        doneBlock = 1'b0;
        blockOUT  = '0;
        lastBlock = 1'b0;
        pktAck    = 1'b0;

        // 1. Reset
        @(posedge clk); @(posedge clk); #1;
        nR = 1'b0;
        chk("rst_pktReady",  {79'd0, pktReady},  80'd0);
        chk("rst_takeBlock", {79'd0, takeBlock}, 80'd0);
        chk("rst_busy",      {79'd0, busy},      80'd0);
        chk("rst_out",       out,                80'd0);
        @(posedge clk); #1;

        // 2. Two blocks into one packet
        expQ.push_back(80'hC000_6565_6877_2140_3F21);
        sendBlock(32'h6565_6877, 1'b0, r);
        chk("half_busy", {79'd0, busy}, 80'd1);
        chk("half_noready", {79'd0, r}, 80'd0);
        sendBlock(32'h2140_3F21, 1'b0, r);
        chk("latency_ready", {79'd0, r}, 80'd1);
        chk("take_count2", 80'(takeCount), 80'd2);

        // 3. Ack held for two cycles
        pktAck = 1'b1;
        @(posedge clk); #1;
        chk("ack_fall", {79'd0, pktReady}, 80'd0);
        @(posedge clk); #1;
        chk("acklow_busy", {79'd0, busy}, 80'd1);
        pktAck = 1'b0;
        @(posedge clk); #1;
        chk("idle_busy", {79'd0, busy}, 80'd0);

        // 4. Odd last block, count must be 1 despite held ack
        expQ.push_back(80'hC301_1918_1110_0000_0000);
        sendBlock(32'h1918_1110, 1'b1, r);
        chk("odd_ready", {79'd0, r}, 80'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("odd_take_count", 80'(takeCount), 80'd3);
        ackPkt();

        // 5. Backpressure: doneBlock held high while packet waits
        expQ.push_back(80'hC002_0123_4567_89AB_CDEF);
        expQ.push_back(80'hC003_DEAD_BEEF_0BAD_F00D);
        sendBlock(32'h0123_4567, 1'b0, r);
        sendBlock(32'h89AB_CDEF, 1'b0, r);
        blockOUT  = 32'hDEAD_BEEF;
        doneBlock = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_no_take", {79'd0, takeBlock}, 80'd0);
        end
        chk("bp_ready", {79'd0, pktReady}, 80'd1);
        pktAck = 1'b1;
        @(posedge clk); #1;
        pktAck = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!takeBlock && n < 10);
        chk("bp_take_after", {79'd0, takeBlock}, 80'd1);
        doneBlock = 1'b0;
        @(posedge clk); #1;
        sendBlock(32'h0BAD_F00D, 1'b0, r);
        ackPkt();

        // 6a. 256 packets: count wraps FF -> 00
        cnt = 8'd4;
        for (int i = 0; i < 256; i++) begin
            a = 32'h1000_0000 + i;
            b = 32'hA5A5_0000 ^ i;
            expQ.push_back({8'hC0, cnt, a, b});
            sendBlock(a, 1'b0, r);
            sendBlock(b, 1'b0, r);
            ackPkt();
            cnt = cnt + 8'd1;
        end

        // 6b. Reset while in HALF discards the held block
        sendBlock(32'hFFFF_FFFF, 1'b0, r);
        nR = 1'b1;
        @(posedge clk); #1;
        nR = 1'b0;
        chk("mid_rst_busy", {79'd0, busy}, 80'd0);
        chk("mid_rst_out",  out,           80'd0);
        expQ.push_back(80'hC000_1357_9BDF_2468_ACE0);
        sendBlock(32'h1357_9BDF, 1'b0, r);
        sendBlock(32'h2468_ACE0, 1'b0, r);
        ackPkt();

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", 80'(expQ.size()), 80'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
